r200id_pipe: RTL
================

# r200id_pipe

Parametrised, pipelined successor to the r200 decode stage. It decodes one RV32 instruction per cycle, reads the register file and builds ALU operands and the branch target. It registers everything into an ID/EX pipeline register with valid/ready handshakes, load-use interlock, flush and write-to-read bypass. It sits between the fetch stage and the execute stage; writeback feeds its register-file write port.

## Interface
- XLEN, 32: datapath width; immediates sign-extend to XLEN; legal values 32 or 64.
- NREGS, 32: architectural registers; 32 (RV32I) or 16 (RV32E).
- BYPASS, 1: 1 = a same-cycle writeback is visible to a same-cycle read; 0 = read returns the old value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  address of if_instr.
- id_ready  out  1  stage accepts if_instr this cycle.
- flush  in  1  squash: EX redirect taken.
- wb_we  in  1  register write enable.
- wb_addr  in  5  register write address.
- wb_data  in  XLEN  register write data.
- ex_ready  in  1  execute accepts ex_* this cycle.
- ex_valid  out  1  ex_* hold a valid instruction.
- ex_pc  out  XLEN  PC of the instruction.
- ex_op1, ex_op2  out  XLEN  ALU operands.
- ex_rs2o  out  XLEN  rs2 value (store data / branch compare).
- ex_brtarg  out  XLEN  branch/jump target.
- ex_rd  out  5  destination register (0 when no write).
- ex_regwr, ex_memwr, ex_memrd, ex_isbr, ex_willjmp  out  1 each  control bits.
- ex_wbsel  out  2  0 = ALU, 1 = memory, 2 = PC+4.
- ex_alu_cont  out  1  instr[30] for OP, and for OP-IMM with funct3=101; otherwise 0.
- ex_illegal  out  1  unrecognised opcode, or register index ≥ NREGS.

## Operation
- Decode covers OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111.
- Any other opcode decodes as a NOP with ex_illegal=1, ex_regwr=0 and ex_memwr=0.
- op1: U-immediate for LUI, otherwise rs1.
- op2 per opcode:
  - OP: rs2.
  - OP-IMM and LOAD: I-immediate.
  - STORE: S-immediate.
  - JAL: if_pc+4.
  - BRANCH: rs2.
  - LUI: 0.
- ex_brtarg: if_pc + B-immediate for BRANCH, if_pc + J-immediate for JAL, otherwise 0. Addition is modulo 2^XLEN.
- ex_willjmp=1 for JAL only; ex_isbr=1 for BRANCH only.
- ex_regwr=1 for OP, OP-IMM, LOAD, LUI and JAL, forced to 0 when rd=0.
- Register file:
  - NREGS×XLEN, two combinational read ports, one write port.
  - x0 always reads 0; writes to x0 are ignored.
  - Writes with wb_addr ≥ NREGS are ignored.
  - With BYPASS=1, a read of an address matching wb_addr while wb_we=1 (address ≠ 0) returns wb_data.
- advance = ex_ready | ~ex_valid.
- Load-use hazard: ex_valid & ex_memrd & ex_rd≠0 & if_valid, and the incoming instruction reads ex_rd through a used source.
  - rs1 is used by all opcodes except LUI and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- id_ready = advance & ~hazard, or 1 when flush=1.
- Register update, priority order:
  1. flush: ex_valid←0; the fetched instruction is consumed and dropped.
  2. advance & hazard: bubble, ex_valid←0.
  3. advance & if_valid: load the decoded instruction, ex_valid←1.
  4. advance & ~if_valid: ex_valid←0.
  5. Otherwise: hold all ex_* unchanged.
- A bubble drives all ex_* control bits to 0. The data fields of a bubble are don't-care.

## Timing
- Decode-to-EX latency is 1 cycle: an instruction accepted at edge N appears on ex_* after edge N.
- id_ready, hazard and the register reads are combinational in the same cycle.
- Writeback-to-read: visible the same cycle with BYPASS=1, the next cycle with BYPASS=0.
- Reset (asynchronous): every ex_* output is 0, including ex_valid=0, and all registers are 0. id_ready is then 1.
- Reset asserted mid-stall discards the held instruction.
- flush together with a hazard: the flush wins, and there is no extra bubble cycle.
- flush together with ex_ready=0: ex_valid still clears; the downstream stage must tolerate this.

## Test plan
- Reset, then feed addi x5,x0,-1 (0xFFF00293) at pc 0x100 with ex_ready=1. One cycle later: ex_valid=1, ex_op1=0, ex_op2=0xFFFFFFFF, ex_rd=5, ex_regwr=1.
- lw x6,0(x1) followed by add x7,x6,x2. The cycle after the lw is accepted, id_ready=0. One bubble (ex_valid=0) follows, then the add issues.
- Hold: ex_ready=0 for 3 cycles with ex_valid=1. ex_* stay constant and id_ready=0.
- Bypass: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF in the same cycle as add x4,x3,x0. ex_op1=0xDEADBEEF with BYPASS=1; the old x3 value with BYPASS=0.
- beq at pc 0x200 with offset −8. ex_brtarg=0x1F8 and ex_isbr=1. The next cycle, flush=1 leaves ex_valid=0.
- NREGS=16: addi x20,x0,1 gives ex_illegal=1 and ex_regwr=0. Opcode 0x7F also gives ex_illegal=1.

Source files
------------

// File: rtl/r200id_pipe_if.sv
// Fetch/writeback/execute-facing signals of the r200id decode stage.
// The slave side is the decode stage; the master side is its surroundings.
interface r200id_pipe_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            flush;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_rs2o;
  logic [XLEN-1:0] ex_brtarg;
  logic [4:0]      ex_rd;
  logic            ex_regwr;
  logic            ex_memwr;
  logic            ex_memrd;
  logic            ex_isbr;
  logic            ex_willjmp;
  logic [1:0]      ex_wbsel;
  logic            ex_alu_cont;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_op1, ex_op2, ex_rs2o, ex_brtarg, ex_rd,
           ex_regwr, ex_memwr, ex_memrd, ex_isbr, ex_willjmp, ex_wbsel,
           ex_alu_cont, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_op1, ex_op2, ex_rs2o, ex_brtarg, ex_rd,
           ex_regwr, ex_memwr, ex_memrd, ex_isbr, ex_willjmp, ex_wbsel,
           ex_alu_cont, ex_illegal
  );
endinterface

// File: rtl/r200id_pipe.sv
// RV32 decode stage: register file, operand build, branch target and the
// ID/EX pipeline register with load-use interlock, flush and write bypass.
module r200id_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  r200id_pipe_if.slave bus
);
  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_OPI = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic [XLEN-1:0] regs [NREGS];

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic            is_op, is_opi, is_ld, is_st, is_br, is_lui, is_jal;
  logic            known, rs1_used, rs2_used, rd_used, illegal, legal, regwr;
  logic            hazard, advance;
  logic [1:0]      wbsel;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] rs1_val, rs2_val, op1, op2, brtarg;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  function automatic logic fits(input logic [4:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  // x0 and out-of-range indices read as zero; bypass only for real writes
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a,
                                                input logic [XLEN-1:0] stored,
                                                input logic we,
                                                input logic [4:0] wa,
                                                input logic [XLEN-1:0] wd);
    if (a == 5'd0 || !fits(a)) return '0;
    if (BYPASS != 0 && we && wa == a) return wd;
    return stored;
  endfunction

  assign instr  = bus.if_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign is_op  = opcode == OPC_OP;
  assign is_opi = opcode == OPC_OPI;
  assign is_ld  = opcode == OPC_LD;
  assign is_st  = opcode == OPC_ST;
  assign is_br  = opcode == OPC_BR;
  assign is_lui = opcode == OPC_LUI;
  assign is_jal = opcode == OPC_JAL;

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  assign rs1_val = read_port(rs1, regs[rs1[AW-1:0]], bus.wb_we, bus.wb_addr, bus.wb_data);
  assign rs2_val = read_port(rs2, regs[rs2[AW-1:0]], bus.wb_we, bus.wb_addr, bus.wb_data);

  always_comb begin
    known    = is_op | is_opi | is_ld | is_st | is_br | is_lui | is_jal;
    rs1_used = ~(is_lui | is_jal);
    rs2_used = is_op | is_st | is_br;
    rd_used  = is_op | is_opi | is_ld | is_lui | is_jal;
    illegal  = ~known | (rd_used & ~fits(rd)) | (rs1_used & ~fits(rs1))
             | (rs2_used & ~fits(rs2));
    legal    = ~illegal;
    regwr    = legal & rd_used & (rd != 5'd0);
    dec_rd   = regwr ? rd : 5'd0;
    wbsel    = 2'd0;
    if (legal && is_ld) wbsel = 2'd1;
    else if (legal && is_jal) wbsel = 2'd2;

    op1 = is_lui ? imm_u : rs1_val;
    op2 = '0;
    if (is_op || is_br) op2 = rs2_val;
    else if (is_opi || is_ld) op2 = imm_i;
    else if (is_st) op2 = imm_s;
    else if (is_jal) op2 = bus.if_pc + XLEN'(4);

    brtarg = '0;
    if (is_br) brtarg = bus.if_pc + imm_b;
    else if (is_jal) brtarg = bus.if_pc + imm_j;
  end

  assign advance = bus.ex_ready | ~bus.ex_valid;
  assign hazard  = bus.ex_valid & bus.ex_memrd & (bus.ex_rd != 5'd0) & bus.if_valid
                 & ((rs1_used & (rs1 == bus.ex_rd)) | (rs2_used & (rs2 == bus.ex_rd)));
  assign bus.id_ready = bus.flush | (advance & ~hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_we && bus.wb_addr != 5'd0 && fits(bus.wb_addr)) begin
      regs[bus.wb_addr[AW-1:0]] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_pc       <= '0;
      bus.ex_op1      <= '0;
      bus.ex_op2      <= '0;
      bus.ex_rs2o     <= '0;
      bus.ex_brtarg   <= '0;
      bus.ex_rd       <= '0;
      bus.ex_regwr    <= 1'b0;
      bus.ex_memwr    <= 1'b0;
      bus.ex_memrd    <= 1'b0;
      bus.ex_isbr     <= 1'b0;
      bus.ex_willjmp  <= 1'b0;
      bus.ex_wbsel    <= '0;
      bus.ex_alu_cont <= 1'b0;
      bus.ex_illegal  <= 1'b0;
    end else if (bus.flush || (advance && (hazard || !bus.if_valid))) begin
      // bubble: control cleared, data fields left as they were
      bus.ex_valid    <= 1'b0;
      bus.ex_rd       <= '0;
      bus.ex_regwr    <= 1'b0;
      bus.ex_memwr    <= 1'b0;
      bus.ex_memrd    <= 1'b0;
      bus.ex_isbr     <= 1'b0;
      bus.ex_willjmp  <= 1'b0;
      bus.ex_wbsel    <= '0;
      bus.ex_alu_cont <= 1'b0;
      bus.ex_illegal  <= 1'b0;
    end else if (advance) begin
      bus.ex_valid    <= 1'b1;
      bus.ex_pc       <= bus.if_pc;
      bus.ex_op1      <= op1;
      bus.ex_op2      <= op2;
      bus.ex_rs2o     <= rs2_val;
      bus.ex_brtarg   <= brtarg;
      bus.ex_rd       <= dec_rd;
      bus.ex_regwr    <= regwr;
      bus.ex_memwr    <= legal & is_st;
      bus.ex_memrd    <= legal & is_ld;
      bus.ex_isbr     <= legal & is_br;
      bus.ex_willjmp  <= legal & is_jal;
      bus.ex_wbsel    <= wbsel;
      bus.ex_alu_cont <= legal & instr[30] & (is_op | (is_opi & instr[14:12] == 3'b101));
      bus.ex_illegal  <= illegal;
    end
  end
endmodule
